// File: rtl/adc_avg_filter.sv
// Moving-average filter for 8-bit ADC samples over a 2^DEPTH_LOG2 window.
// Define ADC_AVG_OV_FAULT_EN to build the sticky over-voltage flag on the averaged value.
module adc_avg_filter #(
   parameter int         DEPTH_LOG2 = 3,
   parameter logic [7:0] OV_LIMIT   = 8'd230
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic [7:0] sample_in,
   input  logic       sample_valid,
   input  logic       clear,
   output logic [7:0] avg_out,
   output logic       avg_valid,
   output logic       fill_done,
   output logic       ov_fault
);

   localparam int N     = 1 << DEPTH_LOG2;
   localparam int SUM_W = 8 + DEPTH_LOG2;
   localparam int CNT_W = DEPTH_LOG2 + 1;

   typedef enum logic {FILL, RUN} state_t;

   state_t                  state;
   logic [7:0]              buffer [N];
   logic [SUM_W-1:0]        sum;
   logic [SUM_W-1:0]        sum_next;
   logic [DEPTH_LOG2-1:0]   wr_ptr;
   logic [CNT_W-1:0]        fill_cnt;

   // The outgoing entry is always part of sum, so the subtraction cannot underflow.
   always_comb begin
      sum_next = sum + SUM_W'(sample_in) - SUM_W'(buffer[wr_ptr]);
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n || clear) begin
         for (int i = 0; i < N; i++) begin
            buffer[i] <= '0;
         end
         sum       <= '0;
         wr_ptr    <= '0;
         fill_cnt  <= '0;
         state     <= FILL;
         avg_out   <= 8'd0;
         avg_valid <= 1'b0;
         fill_done <= 1'b0;
      end else begin
         avg_valid <= 1'b0;
         if (sample_valid) begin
            buffer[wr_ptr] <= sample_in;
            sum            <= sum_next;
            wr_ptr         <= wr_ptr + 1'b1;
            case (state)
               FILL: begin
                  if (fill_cnt != CNT_W'(N)) begin
                     fill_cnt <= fill_cnt + 1'b1;
                  end
                  // The Nth sample completes the window and publishes the first average.
                  if (fill_cnt == CNT_W'(N - 1)) begin
                     state     <= RUN;
                     fill_done <= 1'b1;
                     avg_out   <= sum_next[SUM_W-1:DEPTH_LOG2];
                     avg_valid <= 1'b1;
                  end
               end
               RUN: begin
                  avg_out   <= sum_next[SUM_W-1:DEPTH_LOG2];
                  avg_valid <= 1'b1;
               end
               default: state <= FILL;
            endcase
         end
      end
   end

`ifdef ADC_AVG_OV_FAULT_EN
   // Compares the registered average, so the flag trails the offending update by one cycle.
   always_ff @(posedge sys_clk) begin
      if (!rst_n || clear) begin
         ov_fault <= 1'b0;
      end else if (state == RUN && avg_out > OV_LIMIT) begin
         ov_fault <= 1'b1;
      end
   end
`else
   assign ov_fault = 1'b0;
`endif

endmodule

// File: tb/tb_adc_avg_filter.sv
// Directed self-checking bench for adc_avg_filter with an 8-sample window and limit 230.
module tb_adc_avg_filter;

   logic       sys_clk;
   logic       rst_n;
   logic [7:0] sample_in;
   logic       sample_valid;
   logic       clear;
   logic [7:0] avg_out;
   logic       avg_valid;
   logic       fill_done;
   logic       ov_fault;

   int checks   = 0;
   int failures = 0;

`ifdef ADC_AVG_OV_FAULT_EN
   localparam logic [7:0] OV_EXP = 8'd1;
`else
   localparam logic [7:0] OV_EXP = 8'd0;
`endif

   logic [7:0] exp_200 [8];
   logic [7:0] exp_255 [8];

   adc_avg_filter #(
      .DEPTH_LOG2 (3),
      .OV_LIMIT   (8'd230)
   ) dut (
      .sys_clk      (sys_clk),
      .rst_n        (rst_n),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .clear        (clear),
      .avg_out      (avg_out),
      .avg_valid    (avg_valid),
      .fill_done    (fill_done),
      .ov_fault     (ov_fault)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Drives one cycle of inputs from a falling edge and returns on the next falling edge.
   task automatic applyStimulus(input logic vld, input logic [7:0] data, input logic clr);
      sample_valid = vld;
      sample_in    = data;
      clear        = clr;
      @(negedge sys_clk);
      sample_valid = 1'b0;
      clear        = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   initial begin
      exp_200 = '{8'd112, 8'd125, 8'd137, 8'd150, 8'd162, 8'd175, 8'd187, 8'd200};
      exp_255 = '{8'd206, 8'd213, 8'd220, 8'd227, 8'd234, 8'd241, 8'd248, 8'd255};

      rst_n        = 1'b0;
      sample_in    = 8'd0;
      sample_valid = 1'b0;
      clear        = 1'b0;
      repeat (3) @(negedge sys_clk);
      $display("[TB] reset state");
      checkOutput("rst_avg_out",   avg_out,          8'd0);
      checkOutput("rst_avg_valid", 8'(avg_valid),    8'd0);
      checkOutput("rst_fill_done", 8'(fill_done),    8'd0);
      checkOutput("rst_ov_fault",  8'(ov_fault),     8'd0);
      rst_n = 1'b1;

      $display("[TB] initial fill with 100");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 8'd100, 1'b0);
         checkOutput("fill_no_valid", 8'(avg_valid), 8'd0);
         checkOutput("fill_not_done", 8'(fill_done), 8'd0);
         checkOutput("fill_avg_held", avg_out, 8'd0);
      end
      applyStimulus(1'b1, 8'd100, 1'b0);
      checkOutput("nth_valid",     8'(avg_valid), 8'd1);
      checkOutput("nth_avg",       avg_out,       8'd100);
      checkOutput("nth_fill_done", 8'(fill_done), 8'd1);
      applyStimulus(1'b0, 8'd0, 1'b0);
      checkOutput("idle_no_valid", 8'(avg_valid), 8'd0);
      checkOutput("idle_avg_held", avg_out,       8'd100);
      checkOutput("idle_no_ov",    8'(ov_fault),  8'd0);

      $display("[TB] step to 200 across the wrap");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 8'd200, 1'b0);
         checkOutput("run200_valid", 8'(avg_valid), 8'd1);
         checkOutput("run200_avg",   avg_out,       exp_200[i]);
      end

      $display("[TB] full scale 255");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 8'd255, 1'b0);
         checkOutput("run255_avg", avg_out, exp_255[i]);
         if (i == 4) checkOutput("ov_not_yet", 8'(ov_fault), 8'd0);
      end
      checkOutput("full_scale_ov", 8'(ov_fault), OV_EXP);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 8'd0, 1'b0);
      end
      checkOutput("drop_to_zero_avg", avg_out,      8'd0);
      checkOutput("ov_sticky",        8'(ov_fault), OV_EXP);

      $display("[TB] clear then truncation window");
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("clr_ov",        8'(ov_fault),  8'd0);
      checkOutput("clr_fill_done", 8'(fill_done), 8'd0);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 8'd1, 1'b0);
      end
      checkOutput("trunc_pre_valid", 8'(avg_valid), 8'd0);
      applyStimulus(1'b1, 8'd0, 1'b0);
      checkOutput("trunc_valid", 8'(avg_valid), 8'd1);
      checkOutput("trunc_avg",   avg_out,       8'd0);
      applyStimulus(1'b1, 8'd9, 1'b0);
      checkOutput("trunc_15_avg", avg_out, 8'd1);

      $display("[TB] clear beats sample_valid");
      applyStimulus(1'b1, 8'd200, 1'b1);
      checkOutput("clrsv_avg",       avg_out,       8'd0);
      checkOutput("clrsv_fill_done", 8'(fill_done), 8'd0);
      checkOutput("clrsv_valid",     8'(avg_valid), 8'd0);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 8'd40, 1'b0);
         checkOutput("refill_no_valid", 8'(avg_valid), 8'd0);
      end
      applyStimulus(1'b1, 8'd40, 1'b0);
      checkOutput("refill_valid", 8'(avg_valid), 8'd1);
      checkOutput("refill_avg",   avg_out,       8'd40);

      $display("[TB] reset mid-stream");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'd80, 1'b0);
      end
      checkOutput("pre_rst_avg", avg_out, 8'd65);
      rst_n = 1'b0;
      applyStimulus(1'b1, 8'd255, 1'b1);
      rst_n = 1'b1;
      checkOutput("mid_rst_avg",       avg_out,       8'd0);
      checkOutput("mid_rst_valid",     8'(avg_valid), 8'd0);
      checkOutput("mid_rst_fill_done", 8'(fill_done), 8'd0);
      checkOutput("mid_rst_ov",        8'(ov_fault),  8'd0);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 8'd16, 1'b0);
         checkOutput("post_rst_no_valid", 8'(avg_valid), 8'd0);
      end
      applyStimulus(1'b1, 8'd16, 1'b0);
      checkOutput("post_rst_valid", 8'(avg_valid), 8'd1);
      checkOutput("post_rst_avg",   avg_out,       8'd16);
      checkOutput("post_rst_done",  8'(fill_done), 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_avg_filter.md
ADC_AVG_FILTER -- requirements
Module: adc_avg_filter

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3: log2 of averaging window (window N = 2^DEPTH_LOG2, legal 1..5).
REQ-002 SHALL have parameter OV_LIMIT, default 8'd230: over-voltage threshold on averaged value.
REQ-003 SHALL have port sys_clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port sample_in  in  8  raw ADC conversion result.
REQ-006 SHALL have port sample_valid  in  1  one-cycle strobe qualifying sample_in (ADC data_valid).
REQ-007 SHALL have port clear  in  1  synchronous window flush request.
REQ-008 SHALL have port avg_out  out  8  windowed mean, consumed by PID as voltage_actual.
REQ-009 SHALL have port avg_valid  out  1  one-cycle strobe, avg_out updated.
REQ-010 SHALL have port fill_done  out  1  level, window holds N real samples.
REQ-011 SHALL have port ov_fault  out  1  sticky over-voltage flag.

Function
REQ-012 SHALL store the last N samples in a circular buffer with write pointer of DEPTH_LOG2 bits, wrapping N-1 -> 0 without special handling.
REQ-013 SHALL keep running sum of width 8+DEPTH_LOG2; on accepted sample: sum_next = sum + sample_in - buffer[wr_ptr]; overwrite buffer[wr_ptr]; wr_ptr increments; no overflow possible (max N*255).
REQ-014 SHALL compute avg_out = sum_next >> DEPTH_LOG2 (truncation, no rounding), registered on the same edge that accepts the sample (latency 1 cycle from sample_valid).
REQ-015 SHALL implement two states: FILL (count < N) and RUN; FILL -> RUN on the edge accepting the Nth sample; RUN -> FILL only on clear or reset.
REQ-016 SHALL hold a fill counter of DEPTH_LOG2+1 bits, incrementing per accepted sample in FILL, saturating at N.
REQ-017 SHALL suppress avg_valid in FILL except for the Nth sample; in RUN assert avg_valid one cycle per accepted sample.
REQ-018 SHALL drive fill_done high in RUN, low in FILL.
REQ-019 SHALL hold avg_out unchanged between accepted samples and during FILL.
REQ-020 SHALL on clear: zero all buffer entries, sum, wr_ptr, fill counter, avg_out, avg_valid, ov_fault; enter FILL, all in one cycle.
REQ-021 SHALL give clear priority over simultaneous sample_valid; that sample is dropped.
REQ-022 SHALL accept back-to-back sample_valid on consecutive cycles without loss.

Reset
REQ-023 SHALL on rst_n low at a rising edge set: buffer, sum, wr_ptr, counter = 0; state FILL; avg_out=8'd0, avg_valid=0, fill_done=0, ov_fault=0.
REQ-024 SHALL give rst_n priority over clear and sample_valid; reset mid-fill or mid-run discards all history.

Configuration
REQ-025 SHALL with macro ADC_AVG_OV_FAULT_EN defined: in RUN set ov_fault when registered avg_out > OV_LIMIT, hold until clear or reset.
REQ-026 SHALL without ADC_AVG_OV_FAULT_EN: contain no comparator/flag logic, ov_fault tied to 0.

Verification (DEPTH_LOG2=3, OV_LIMIT=230)
REQ-027 SHALL cover: reset, 8 samples of 100 -> avg_valid only after 8th, avg_out=100, fill_done=1 one cycle after 8th strobe.
REQ-028 SHALL cover: steady 100 in RUN, then samples of 200 -> avg_out 150 after 4th, 200 after 8th; wr_ptr wraps cleanly.
REQ-029 SHALL cover: 8 samples of 255 -> avg_out=255 (sum 2040, no overflow); with macro ov_fault=1 and stays 1 after samples drop to 0; without macro ov_fault=0.
REQ-030 SHALL cover: samples 1,1,1,1,1,1,1,0 -> avg_out=0 (truncation).
REQ-031 SHALL cover: clear asserted same cycle as sample_valid in RUN -> sample dropped, avg_out=0, fill_done=0, 8 new samples needed before next avg_valid.
REQ-032 SHALL cover: rst_n low after 5 samples, back-to-back strobes -> all outputs 0; refill needs full 8 samples.
